// File: rtl/ddr4_bist_sequencer.sv
// DDR4 built-in self test sequencer: waits for EMIF calibration, writes an
// address-derived pattern over TEST_WORDS words, reads them back with a bounded
// number of reads in flight, and reports pass/fail, error count and first bad word.
module ddr4_bist_sequencer #(
    parameter int unsigned ADDR_W          = 25,
    parameter int unsigned DATA_W          = 576,
    parameter int unsigned TEST_WORDS      = 1024,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter logic [31:0] SEED            = 32'hA5C3_0F96
) (
    input  logic                mem_clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cal_success,
    input  logic                cal_fail,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [6:0]          avm_burstcount,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_W:0] LastIdx  = (ADDR_W + 1)'(TEST_WORDS - 1);
    localparam logic [ADDR_W:0] NumWords = (ADDR_W + 1)'(TEST_WORDS);
    localparam logic [OutW-1:0] MaxOut   = OutW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        StIdle, StWaitCal, StWrite, StRead, StDrain, StPass, StFail
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   ridx_q, ridx_d;
    logic [OutW-1:0]   out_q, out_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic start_run, last_idx, rd_room, wr_accept, rd_accept, ret_valid, ret_dec;

    // 32-bit word {a zero-extended} ^ SEED, replicated across the data bus
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W:0] a);
        logic [31:0] w;
        w = 32'(a) ^ SEED;
        return {(DATA_W / 32){w}};
    endfunction

    assign start_run = start && (state_q == StIdle || state_q == StPass || state_q == StFail);
    assign last_idx  = ({1'b0, idx_q} == LastIdx);
    assign rd_room   = (out_q < MaxOut);
    assign wr_accept = (state_q == StWrite) && !avm_waitrequest;
    assign rd_accept = (state_q == StRead) && rd_room && !avm_waitrequest;
    // Returns are only meaningful while a read phase is active; stale ones are dropped
    assign ret_valid = avm_readdatavalid && (state_q == StRead || state_q == StDrain);
    assign ret_dec   = ret_valid && (out_q != '0);

    assign avm_address    = idx_q;
    assign avm_writedata  = (state_q == StWrite) ? pattern({1'b0, idx_q}) : '0;
    assign avm_byteenable = '1;
    assign avm_burstcount = 7'd1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

    // State register
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and command strobes
    always_comb begin
        state_d   = state_q;
        avm_write = 1'b0;
        avm_read  = 1'b0;
        unique case (state_q)
            StIdle, StPass, StFail: begin
                if (start) state_d = StWaitCal;
            end
            StWaitCal: begin
                if (cal_fail)         state_d = StFail;
                else if (cal_success) state_d = StWrite;
            end
            StWrite: begin
                avm_write = 1'b1;
                if (wr_accept && last_idx) state_d = StRead;
            end
            StRead: begin
                // Held high through a stall: outstanding can only fall meanwhile
                avm_read = rd_room;
                if (rd_accept && last_idx) state_d = StDrain;
            end
            StDrain: begin
                if (out_q == '0 && ridx_q == NumWords) begin
                    state_d = (err_q == 16'd0) ? StPass : StFail;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: indices, outstanding counter, error capture and status
    always_comb begin
        idx_d   = idx_q;
        ridx_d  = ridx_q;
        out_d   = out_q;
        err_d   = err_q;
        first_d = first_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (start_run) begin
            idx_d   = '0;
            ridx_d  = '0;
            out_d   = '0;
            err_d   = '0;
            first_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end

        if (wr_accept || rd_accept) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end

        if (ret_valid) begin
            ridx_d = ridx_q + 1'b1;
            if (avm_readdata != pattern(ridx_q)) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == 16'd0)    first_d = ridx_q[ADDR_W-1:0];
            end
        end

        case ({rd_accept, ret_dec})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase

        if (state_d != state_q && (state_d == StPass || state_d == StFail)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (state_d == StPass);
        end
    end

    // Datapath registers
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            ridx_q  <= '0;
            out_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            ridx_q  <= ridx_d;
            out_q   <= out_d;
            err_q   <= err_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_ddr4_bist_sequencer.sv
// Bench for ddr4_bist_sequencer: two instances (4 and 2 reads in flight) each
// served by a behavioural memory with programmable latency, stalls and corruption.
module tb_ddr4_bist_sequencer;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 8;
    localparam logic [31:0] SEED = 32'hA5C3_0F96;
    localparam logic [DW-1:0] Flip = 64'h0000_0100_0000_0001;

    logic mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    logic          reset[2]       = '{1'b1, 1'b1};
    logic          start[2]       = '{1'b0, 1'b0};
    logic          cal_success[2] = '{1'b0, 1'b0};
    logic          cal_fail[2]    = '{1'b0, 1'b0};
    logic          wreq[2]        = '{1'b0, 1'b0};
    logic          rdv[2]         = '{1'b0, 1'b0};
    logic [DW-1:0] rdata[2]       = '{'0, '0};

    logic          av_write[2], av_read[2], busy[2], done[2], pass[2];
    logic [AW-1:0] addr[2], ferr[2];
    logic [DW-1:0] wdata[2];
    logic [DW/8-1:0] be[2];
    logic [6:0]    bc[2];
    logic [15:0]   errc[2];

    int total = 0;
    int bad = 0;

    ddr4_bist_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .TEST_WORDS(TW), .MAX_OUTSTANDING(4), .SEED(SEED)
    ) u_dut_a (
        .mem_clk(mem_clk), .reset(reset[0]), .start(start[0]),
        .cal_success(cal_success[0]), .cal_fail(cal_fail[0]),
        .avm_address(addr[0]), .avm_write(av_write[0]), .avm_read(av_read[0]),
        .avm_writedata(wdata[0]), .avm_byteenable(be[0]), .avm_burstcount(bc[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_err_addr(ferr[0])
    );

    ddr4_bist_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .TEST_WORDS(TW), .MAX_OUTSTANDING(2), .SEED(SEED)
    ) u_dut_b (
        .mem_clk(mem_clk), .reset(reset[1]), .start(start[1]),
        .cal_success(cal_success[1]), .cal_fail(cal_fail[1]),
        .avm_address(addr[1]), .avm_write(av_write[1]), .avm_read(av_read[1]),
        .avm_writedata(wdata[1]), .avm_byteenable(be[1]), .avm_burstcount(bc[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_err_addr(ferr[1])
    );

    function automatic void check(input string tag, input logic [63:0] obs,
                                  input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] r;
        logic [31:0]   w;
        w = 32'(a) ^ SEED;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = w;
        return r;
    endfunction

    // ---------------- behavioural memory / bus monitor ----------------
    typedef struct {
        int            g;
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] mem[2][TW];
    int            cyc = 0;
    int            wr_cnt[2], rd_cnt[2], inflight[2], seen_id[2];
    int            run_id[2], lat[2];
    logic          stall_en[2] = '{1'b0, 1'b0};
    logic [TW-1:0] corrupt[2]  = '{'0, '0};
    logic          p_stall[2]  = '{1'b0, 1'b0};
    logic          p_wr[2], p_rd[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_data[2];

    always @(negedge mem_clk) begin
        logic aw, ar, rt;
        int   hit;
        ret_t e;
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (seen_id[g] != run_id[g]) begin
                seen_id[g] = run_id[g];
                wr_cnt[g]  = 0;
                rd_cnt[g]  = 0;
            end
            if (reset[g]) p_stall[g] = 1'b0;
            check("excl", 64'(av_write[g] && av_read[g]), 64'd0);
            if (!busy[g]) check("idle_cmd", 64'(av_write[g] || av_read[g]), 64'd0);
            if (p_stall[g]) begin
                check("hold_wr", 64'(av_write[g]), 64'(p_wr[g]));
                check("hold_rd", 64'(av_read[g]), 64'(p_rd[g]));
                check("hold_addr", 64'(addr[g]), 64'(p_addr[g]));
                if (p_wr[g]) check("hold_data", wdata[g], p_data[g]);
            end
            if (g == 1 && av_read[g]) check("limit", 64'(inflight[g] < 2), 64'd1);

            wreq[g] = stall_en[g] ? 1'($urandom_range(0, 1)) : 1'b0;
            aw = av_write[g] && !wreq[g];
            ar = av_read[g] && !wreq[g];
            if (aw) begin
                check("wr_addr", 64'(addr[g]), 64'(wr_cnt[g]));
                check("wr_data", wdata[g], pat(wr_cnt[g]));
                mem[g][addr[g][2:0]] = wdata[g];
                wr_cnt[g]++;
            end
            if (ar) begin
                check("rd_addr", 64'(addr[g]), 64'(rd_cnt[g]));
                check("rd_after_wr", 64'(wr_cnt[g]), 64'(TW));
                e.g    = g;
                e.due  = cyc + lat[g];
                e.data = mem[g][addr[g][2:0]] ^ (corrupt[g][addr[g][2:0]] ? Flip : '0);
                rq.push_back(e);
                rd_cnt[g]++;
            end

            hit = -1;
            for (int i = 0; i < rq.size(); i++) begin
                if (hit < 0 && rq[i].g == g) hit = i;
            end
            rt = 1'b0;
            if (hit >= 0) begin
                if (rq[hit].due <= cyc) rt = 1'b1;
            end
            rdv[g]   = rt;
            rdata[g] = '0;
            if (rt) begin
                rdata[g] = rq[hit].data;
                rq.delete(hit);
            end
            inflight[g] += int'(ar) - int'(rt);

            p_stall[g] = (av_write[g] || av_read[g]) && wreq[g];
            p_wr[g]    = av_write[g];
            p_rd[g]    = av_read[g];
            p_addr[g]  = addr[g];
            p_data[g]  = wdata[g];
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic pulse_start(input int g, input string tag);
        @(negedge mem_clk);
        start[g] = 1'b1;
        @(negedge mem_clk);
        start[g] = 1'b0;
        check({tag, "_busy"}, 64'(busy[g]), 64'd1);
        check({tag, "_done_clr"}, 64'(done[g]), 64'd0);
        check({tag, "_err_clr"}, 64'(errc[g]), 64'd0);
    endtask

    task automatic wait_done(input int g, input string tag);
        int n;
        n = 0;
        while (!done[g] && n < 4000) begin
            @(negedge mem_clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(done[g]), 64'd1);
    endtask

    task automatic run(input int g, input string tag, input int l, input logic st,
                       input logic [TW-1:0] cm, input logic poke);
        int nerr, first;
        lat[g] = l; stall_en[g] = st; corrupt[g] = cm; run_id[g]++;
        cal_success[g] = 1'b1; cal_fail[g] = 1'b0;
        pulse_start(g, tag);
        if (poke) begin
            tick(3);
            start[g] = 1'b1; cal_fail[g] = 1'b1;
            tick(1);
            start[g] = 1'b0;
            tick(2);
            cal_fail[g] = 1'b0;
        end
        wait_done(g, tag);
        nerr  = $countones(cm);
        first = 0;
        for (int i = TW - 1; i >= 0; i--) if (cm[i]) first = i;
        check({tag, "_pass"}, 64'(pass[g]), 64'(nerr == 0));
        check({tag, "_errc"}, 64'(errc[g]), 64'(nerr));
        check({tag, "_first"}, 64'(ferr[g]), 64'(first));
        check({tag, "_busy_end"}, 64'(busy[g]), 64'd0);
        check({tag, "_nwr"}, 64'(wr_cnt[g]), 64'(TW));
        check({tag, "_nrd"}, 64'(rd_cnt[g]), 64'(TW));
        stall_en[g] = 1'b0;
    endtask

    task automatic cal_run(input int g, input string tag, input logic s, input logic f);
        lat[g] = 5; stall_en[g] = 1'b0; corrupt[g] = '0; run_id[g]++;
        cal_success[g] = s; cal_fail[g] = f;
        pulse_start(g, tag);
        wait_done(g, tag);
        check({tag, "_pass"}, 64'(pass[g]), 64'd0);
        check({tag, "_errc"}, 64'(errc[g]), 64'd0);
        check({tag, "_nwr"}, 64'(wr_cnt[g]), 64'd0);
        check({tag, "_nrd"}, 64'(rd_cnt[g]), 64'd0);
        cal_fail[g] = 1'b0;
    endtask

    task automatic check_zero(input int g, input string tag);
        check({tag, "_write"}, 64'(av_write[g]), 64'd0);
        check({tag, "_read"}, 64'(av_read[g]), 64'd0);
        check({tag, "_addr"}, 64'(addr[g]), 64'd0);
        check({tag, "_wdata"}, wdata[g], 64'd0);
        check({tag, "_busy"}, 64'(busy[g]), 64'd0);
        check({tag, "_done"}, 64'(done[g]), 64'd0);
        check({tag, "_pass"}, 64'(pass[g]), 64'd0);
        check({tag, "_errc"}, 64'(errc[g]), 64'd0);
        check({tag, "_ferr"}, 64'(ferr[g]), 64'd0);
    endtask

    initial begin
        int n;
        lat = '{5, 5};
        tick(3);
        for (int g = 0; g < 2; g++) begin
            check_zero(g, "rst");
            check("rst_be", 64'(be[g]), 64'hFF);
            check("rst_bc", 64'(bc[g]), 64'd1);
        end
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick(2);

        run(0, "clean", 5, 1'b0, 8'h00, 1'b0);
        run(0, "corrupt", 5, 1'b0, 8'b0100_1000, 1'b0);
        run(1, "limit", 10, 1'b0, 8'h00, 1'b0);
        run(0, "stall", $urandom_range(1, 8), 1'b1, 8'h00, 1'b1);
        run(0, "rand", $urandom_range(1, 12), 1'b1, 8'($urandom), 1'b0);
        cal_run(0, "calfail", 1'b0, 1'b1);
        cal_run(0, "calboth", 1'b1, 1'b1);

        // Reset with four reads in flight
        lat[0] = 10; stall_en[0] = 1'b0; corrupt[0] = '0; run_id[0]++;
        cal_success[0] = 1'b1; cal_fail[0] = 1'b0;
        pulse_start(0, "midrst");
        n = 0;
        while (inflight[0] < 4 && n < 200) begin
            @(negedge mem_clk);
            n++;
        end
        check("midrst_reach4", 64'(inflight[0]), 64'd4);
        @(posedge mem_clk);
        #2;
        reset[0] = 1'b1;
        #1;
        check_zero(0, "midrst");
        @(negedge mem_clk);
        reset[0] = 1'b0;
        n = 0;
        while (inflight[0] != 0 && n < 200) begin
            @(negedge mem_clk);
            n++;
        end
        check("midrst_drained", 64'(inflight[0]), 64'd0);
        check("midrst_ign_errc", 64'(errc[0]), 64'd0);
        check("midrst_ign_done", 64'(done[0]), 64'd0);
        run(0, "after_rst", 5, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr4_bist_sequencer.md
DDR4_BIST_SEQUENCER -- requirements
Module: ddr4_bist_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: width of the Avalon-MM word address.
REQ-002 SHALL have parameter DATA_W, default 576: data width, which shall be a multiple of 32.
REQ-003 SHALL have parameter TEST_WORDS, default 1024: number of words tested, range 1..2^ADDR_W.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16: maximum reads in flight, range 1..64.
REQ-005 SHALL have parameter SEED, default 32'hA5C3_0F96: pattern seed.
REQ-006 SHALL have port mem_clk, in, 1: the single clock (EMIF user clock); all logic is synchronous to it.
REQ-007 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start, in, 1: one-cycle request to run a test.
REQ-009 SHALL have port cal_success, in, 1: EMIF calibration passed (level).
REQ-010 SHALL have port cal_fail, in, 1: EMIF calibration failed (level).
REQ-011 SHALL have port avm_address, out, ADDR_W: word address.
REQ-012 SHALL have ports avm_write and avm_read, out, 1 each: command strobes.
REQ-013 SHALL have port avm_writedata, out, DATA_W: write data.
REQ-014 SHALL have port avm_byteenable, out, DATA_W/8: always all ones.
REQ-015 SHALL have port avm_burstcount, out, 7: always 1.
REQ-016 SHALL have port avm_waitrequest, in, 1: slave stall.
REQ-017 SHALL have ports avm_readdata, in, DATA_W, and avm_readdatavalid, in, 1: read return path.
REQ-018 SHALL have ports busy, done and pass, out, 1 each: status.
REQ-019 SHALL have port err_count, out, 16: saturating count of mismatched words.
REQ-020 SHALL have port first_err_addr, out, ADDR_W: address of the first mismatched word.

Function
REQ-021 SHALL use pattern(a) = 32-bit value {a zero-extended to 32 bits} XOR SEED, replicated DATA_W/32 times.
REQ-022 SHALL implement the states IDLE, WAIT_CAL, WRITE, READ, DRAIN, PASS and FAIL.
REQ-023 SHALL move from IDLE, PASS or FAIL to WAIT_CAL on start; in that cycle it clears err_count, first_err_addr, done and pass, and sets busy.
REQ-024 SHALL ignore start in WAIT_CAL, WRITE, READ and DRAIN.
REQ-025 SHALL, in WAIT_CAL, go to FAIL when cal_fail=1 (cal_fail has priority over cal_success), otherwise go to WRITE when cal_success=1.
REQ-026 SHALL, in WRITE, assert avm_write with avm_address=idx and avm_writedata=pattern(idx), where idx starts at 0.
REQ-027 SHALL advance idx only in a cycle with avm_waitrequest=0.
REQ-028 SHALL hold the command, address and data stable while avm_waitrequest=1.
REQ-029 SHALL, after idx=TEST_WORDS-1 is accepted, reset idx to 0 and go to READ, with no idle cycle required.
REQ-030 SHALL, in READ, assert avm_read at address idx only while outstanding<MAX_OUTSTANDING, and deassert it otherwise.
REQ-031 SHALL not drop a read that is presented while avm_waitrequest=1.
REQ-032 SHALL, after the last read is accepted, go to DRAIN.
REQ-033 SHALL track outstanding with a counter: +1 on an accepted read, -1 on avm_readdatavalid; both in the same cycle leave it unchanged.
REQ-034 SHALL compare each avm_readdatavalid word against pattern(ridx), where ridx counts returns in order from 0.
REQ-035 SHALL, on a mismatch, increment err_count (saturating at 16'hFFFF), and capture ridx into first_err_addr only if err_count was 0.
REQ-036 SHALL process returns arriving in the READ state identically to those in DRAIN.
REQ-037 SHALL, in DRAIN, once outstanding=0 and ridx=TEST_WORDS, go to PASS if err_count=0, else to FAIL.
REQ-038 SHALL, on entry to PASS, set busy=0, done=1 and pass=1; on entry to FAIL, set busy=0, done=1 and pass=0; both hold until the next start.
REQ-039 SHALL keep avm_write and avm_read mutually exclusive, and never assert either outside WRITE/READ.
REQ-040 SHALL ignore cal_fail after WAIT_CAL.
REQ-041 SHALL ignore avm_readdatavalid in IDLE, PASS and FAIL (no counter change).

Reset
REQ-042 SHALL, on reset assertion and irrespective of clock or state, immediately enter IDLE and drive avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, busy=0, done=0, pass=0, err_count=0 and first_err_addr=0, with idx, ridx and outstanding all =0.
REQ-043 SHALL, when reset is asserted mid-test, abandon in-flight reads; returns after release are ignored per REQ-041.

Verification
REQ-044 SHALL verify a clean run: TEST_WORDS=8, ideal memory model, waitrequest=0, read latency 5 -> 8 writes then 8 reads, done=1, pass=1, err_count=0.
REQ-045 SHALL verify an error capture: the model corrupts words 3 and 6 -> pass=0, err_count=2, first_err_addr=3.
REQ-046 SHALL verify the outstanding limit: MAX_OUTSTANDING=2, read latency 10 -> avm_read is never asserted with 2 reads in flight, and the result is pass.
REQ-047 SHALL verify stalls: random waitrequest at 50% -> command and data stable during every stall, and the same transaction sequence as the clean run.
REQ-048 SHALL verify calibration handling: cal_fail=1 in WAIT_CAL -> FAIL with no Avalon command issued; cal_success and cal_fail both high -> FAIL.
REQ-049 SHALL verify reset mid-READ: assert reset with 4 reads outstanding -> all outputs zero the same cycle; a new start then yields a clean pass.
